// File: rtl/tape_adc_frontend.sv
// Tape-input front end: SPI master for an ADC128S022-style ADC, frame averaging, and a hysteresis slicer for the ULA EAR bit.
// Optional feature macro TAPE_DC_TRACK_EN: the slicer midpoint follows the tape's DC level through an IIR tracker.
module tape_adc_frontend #(
    parameter int ADC_BITS    = 12,
    parameter int CLK_DIV     = 4,
    parameter int AVG_LOG2    = 2,
    parameter int HYST        = 64,
    parameter int LOSS_FRAMES = 4096,
    parameter int DC_SHIFT    = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          ch_sel,
    input  logic                din,
    output logic                dout,
    output logic                dclk,
    output logic                dcsn,
    output logic [ADC_BITS-1:0] sample,
    output logic                sample_vld,
    output logic                ear,
    output logic                sig_lost
);
    // dcsn stays high for two dclk periods between frames, giving 36*CLK_DIV+1 clk per frame
    localparam int IDLE_CLKS = 4 * CLK_DIV;
    localparam int DW        = $clog2(IDLE_CLKS);
    localparam int ACC_W     = ADC_BITS + AVG_LOG2;
    localparam int FW        = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int LW        = $clog2(LOSS_FRAMES + 1);
    localparam int CODE_MAX  = (1 << ADC_BITS) - 1;
    localparam int MID       = 1 << (ADC_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    logic [DW-1:0]       div_cnt;
    logic [3:0]          cyc;
    logic [2:0]          ch_q;
    logic [ADC_BITS-1:0] shreg;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_sum;
    logic [FW-1:0]       frame_cnt;
    logic [LW-1:0]       loss_cnt;
    logic [ADC_BITS-1:0] mid;
    logic [ADC_BITS-1:0] hi;
    logic [ADC_BITS-1:0] lo;
    logic                ear_next;
    int                  hi_i;
    int                  lo_i;

`ifdef TAPE_DC_TRACK_EN
    localparam int MW = ADC_BITS + DC_SHIFT;
    logic [MW-1:0]       mid_acc;
    logic signed [MW:0]  mid_diff;
    logic signed [MW:0]  mid_step;
`endif

    // Channel address bits ride on dclk cycles 2..4, MSB first
    function automatic logic dout_bit(input logic [3:0] c, input logic [2:0] ch);
        case (c)
            4'd2:    dout_bit = ch[2];
            4'd3:    dout_bit = ch[1];
            4'd4:    dout_bit = ch[0];
            default: dout_bit = 1'b0;
        endcase
    endfunction

    // Running sum of the current frame's raw result into the accumulator
    always_comb begin
        acc_sum = acc + ACC_W'(shreg);
    end

    // SPI frame sequencer and frame averaging
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            div_cnt    <= '0;
            cyc        <= 4'd0;
            ch_q       <= 3'd0;
            shreg      <= '0;
            acc        <= '0;
            frame_cnt  <= '0;
            dcsn       <= 1'b1;
            dclk       <= 1'b1;
            dout       <= 1'b0;
            sample     <= '0;
            sample_vld <= 1'b0;
        end else begin
            sample_vld <= 1'b0;
            case (state)
                IDLE: begin
                    dcsn <= 1'b1;
                    dclk <= 1'b1;
                    dout <= 1'b0;
                    if (div_cnt == DW'(IDLE_CLKS - 1)) begin
                        div_cnt <= '0;
                        cyc     <= 4'd0;
                        state   <= FRAME;
                        dcsn    <= 1'b0;
                        dclk    <= 1'b0;
                        ch_q    <= ch_sel;
                        // Averaging across a channel switch would mix unrelated signals
                        if (ch_sel != ch_q) begin
                            acc       <= '0;
                            frame_cnt <= '0;
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                FRAME: begin
                    if (div_cnt == DW'(CLK_DIV - 1)) begin
                        div_cnt <= '0;
                        if (!dclk) begin
                            dclk <= 1'b1;
                            if (cyc >= 4'd4) begin
                                shreg <= {shreg[ADC_BITS-2:0], din};
                            end
                        end else if (cyc == 4'd15) begin
                            state <= DONE;
                            dcsn  <= 1'b1;
                            dout  <= 1'b0;
                        end else begin
                            dclk <= 1'b0;
                            cyc  <= cyc + 4'd1;
                            dout <= dout_bit(cyc + 4'd1, ch_q);
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                DONE: begin
                    dcsn    <= 1'b1;
                    dclk    <= 1'b1;
                    dout    <= 1'b0;
                    state   <= IDLE;
                    div_cnt <= '0;
                    if (frame_cnt == FW'((1 << AVG_LOG2) - 1)) begin
                        sample     <= ADC_BITS'(acc_sum >> AVG_LOG2);
                        sample_vld <= 1'b1;
                        acc        <= '0;
                        frame_cnt  <= '0;
                    end else begin
                        acc       <= acc_sum;
                        frame_cnt <= frame_cnt + FW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    div_cnt <= '0;
                    dcsn    <= 1'b1;
                    dclk    <= 1'b1;
                    dout    <= 1'b0;
                end
            endcase
        end
    end

    // Slicer thresholds, saturated to the code range, and the next EAR level
    always_comb begin
`ifdef TAPE_DC_TRACK_EN
        mid      = mid_acc[MW-1:DC_SHIFT];
        mid_diff = $signed({1'b0, sample, {DC_SHIFT{1'b0}}}) - $signed({1'b0, mid_acc});
        mid_step = mid_diff >>> DC_SHIFT;
`else
        mid = ADC_BITS'(MID);
`endif
        hi_i = int'(mid) + HYST;
        lo_i = int'(mid) - HYST;
        if (hi_i > CODE_MAX) begin
            hi = ADC_BITS'(CODE_MAX);
        end else begin
            hi = ADC_BITS'(hi_i);
        end
        if (lo_i < 0) begin
            lo = '0;
        end else begin
            lo = ADC_BITS'(lo_i);
        end
        if (sample > hi) begin
            ear_next = 1'b1;
        end else if (sample < lo) begin
            ear_next = 1'b0;
        end else begin
            ear_next = ear;
        end
    end

    // EAR register, loss-of-signal counter and optional midpoint tracker
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ear      <= 1'b0;
            sig_lost <= 1'b1;
            loss_cnt <= '0;
`ifdef TAPE_DC_TRACK_EN
            mid_acc  <= MW'(MID) << DC_SHIFT;
`endif
        end else if (sample_vld) begin
            if (ear_next != ear) begin
                ear      <= ear_next;
                loss_cnt <= '0;
                sig_lost <= 1'b0;
            end else if (loss_cnt == LW'(LOSS_FRAMES)) begin
                sig_lost <= 1'b1;
            end else begin
                loss_cnt <= loss_cnt + LW'(1);
                sig_lost <= (loss_cnt == LW'(LOSS_FRAMES - 1));
            end
`ifdef TAPE_DC_TRACK_EN
            mid_acc <= mid_acc + mid_step[MW-1:0];
`endif
        end else begin
            sig_lost <= sig_lost;
        end
    end

endmodule
